rv32e_regfile: RTL and testbench

//   Architectural integer register file of the RV32E NPC core: 16 x 32-bit GPRs, x0 hardwired to 0.

---
 rtl/rv32e_regfile.sv | 47 ++++
 tb/tb_rv32e_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv32e_regfile.sv
// rv32e_regfile: RV32E GPR file with handshaked writeback, bypassed read ports and difftest snapshot
module rv32e_regfile #(
    parameter int NR_REGS = 16,
    parameter int XLEN    = 32,
    parameter bit BYPASS  = 1'b1,
    parameter int AW      = $clog2(NR_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [AW-1:0]           wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    dbg_hold,
    input  logic [AW-1:0]           rs1_addr,
    output logic [XLEN-1:0]         rs1_data,
    input  logic [AW-1:0]           rs2_addr,
    output logic [XLEN-1:0]         rs2_data,
    output logic [NR_REGS*XLEN-1:0] dbg_regs,
    output logic                    dbg_valid,
    output logic [31:0]             commit_cnt
);
    // x0 has no storage; its snapshot slot and reads are constant zero
    logic [XLEN-1:0] gpr [1:NR_REGS-1];
    logic acc;
    assign wb_ready = !rst && !dbg_hold;
    assign acc = wb_valid && wb_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NR_REGS; i++) gpr[i] <= '0;
            dbg_valid <= 1'b0;
            commit_cnt <= '0;
        end else begin
            if (acc && wb_rd != '0) gpr[wb_rd] <= wb_data;
            dbg_valid <= acc;
            if (acc) commit_cnt <= commit_cnt + 32'd1;
        end
    end
    always_comb begin
        dbg_regs = '0;
        for (int i = 1; i < NR_REGS; i++) dbg_regs[i*XLEN +: XLEN] = gpr[i];
    end
    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (BYPASS && acc && wb_rd == rs1_addr) ? wb_data : dbg_regs[rs1_addr*XLEN +: XLEN];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (BYPASS && acc && wb_rd == rs2_addr) ? wb_data : dbg_regs[rs2_addr*XLEN +: XLEN];
endmodule

// File: tb/tb_rv32e_regfile.sv
// tb_rv32e_regfile: scoreboard bench; each accepted writeback queues the expected snapshot for its dbg_valid cycle
module tb_rv32e_regfile;
    logic        clk = 1'b0;
    logic        rst, wb_valid, wb_ready, dbg_hold, dbg_valid;
    logic [3:0]  wb_rd, rs1_addr, rs2_addr;
    logic [31:0] wb_data, rs1_data, rs2_data, commit_cnt;
    logic [511:0] dbg_regs;

    typedef struct packed {
        logic [511:0] regs;
        logic [31:0]  cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [16];
    logic [31:0] cnt;
    int          checks = 0;
    int          errors = 0;

    rv32e_regfile dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .dbg_hold(dbg_hold), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .dbg_regs(dbg_regs), .dbg_valid(dbg_valid),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = '0;
        cnt = '0;
        q.delete();
    endtask

    // advance one clock; the model commits what the bench itself drove
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (wb_valid && !dbg_hold && !rst) begin
            cnt = cnt + 32'd1;
            if (wb_rd != 4'd0) model[wb_rd] = wb_data;
            for (int i = 0; i < 16; i++) e.regs[i*32 +: 32] = model[i];
            e.cnt = cnt;
            q.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        step();
        wb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("dbg_valid_pulse", {31'b0, dbg_valid}, 32'd1);
                for (int i = 0; i < 16; i++) check($sformatf("dbg_regs[%0d]", i), dbg_regs[i*32 +: 32], e.regs[i*32 +: 32]);
                check("commit_cnt_sb", commit_cnt, e.cnt);
            end else if (dbg_valid) begin
                check("spurious_dbg_valid", {31'b0, dbg_valid}, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; dbg_hold = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        model_reset();
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) check("rst_regs", dbg_regs[i*32 +: 32], 32'd0);
        check("rst_cnt", commit_cnt, 32'd0);
        check("rst_ready", {31'b0, wb_ready}, 32'd0);
        check("rst_valid", {31'b0, dbg_valid}, 32'd0);
        step();
        rst = 1'b0;
        #1 check("ready_after_rst", {31'b0, wb_ready}, 32'd1);

        write(4'd5, 32'hDEADBEEF);
        rs1_addr = 4'd5; rs2_addr = 4'd5;
        #1 check("rs1_x5", rs1_data, 32'hDEADBEEF);
        check("rs2_x5", rs2_data, 32'hDEADBEEF);
        check("cnt_1", commit_cnt, 32'd1);

        write(4'd0, 32'h12345678);
        rs1_addr = 4'd0; rs2_addr = 4'd0;
        #1 check("rs1_x0", rs1_data, 32'd0);
        check("rs2_x0", rs2_data, 32'd0);
        check("cnt_2", commit_cnt, 32'd2);

        write(4'd7, 32'h1);
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'hA5A5A5A5; dbg_hold = 1'b1;
        rs1_addr = 4'd7; rs2_addr = 4'd7;
        #1 check("hold_no_fwd", rs2_data, 32'h1);
        check("hold_ready", {31'b0, wb_ready}, 32'd0);
        step();
        dbg_hold = 1'b0;
        #1 check("fwd_rs2", rs2_data, 32'hA5A5A5A5);
        check("fwd_rs1_same", rs1_data, 32'hA5A5A5A5);
        step();
        wb_valid = 1'b0;
        #1 check("x7_stored", rs2_data, 32'hA5A5A5A5);

        wb_valid = 1'b1; wb_rd = 4'd9; wb_data = 32'h0BADF00D; dbg_hold = 1'b1;
        repeat (3) step();
        check("hold_cnt", commit_cnt, cnt);
        check("hold_x9", dbg_regs[9*32 +: 32], 32'd0);
        dbg_hold = 1'b0;
        step();
        wb_valid = 1'b0;
        step();
        check("hold_release_cnt", commit_cnt, 32'd5);
        rs1_addr = 4'd9;
        #1 check("hold_release_x9", rs1_data, 32'h0BADF00D);

        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1'b1; wb_rd = 4'(i); wb_data = 32'h1000 + 32'(i);
            step();
        end
        wb_valid = 1'b0;
        for (int n = 0; n < 24; n++) begin
            wb_valid = 1'($urandom_range(0, 1));
            dbg_hold = ($urandom_range(0, 3) == 0);
            wb_rd = 4'($urandom_range(0, 15));
            wb_data = $urandom;
            rs1_addr = 4'($urandom_range(0, 15));
            rs2_addr = 4'($urandom_range(0, 15));
            #1;
            check("rnd_rs1", rs1_data, (rs1_addr == 0) ? 32'd0 :
                  (wb_valid && !dbg_hold && wb_rd == rs1_addr) ? wb_data : model[rs1_addr]);
            check("rnd_rs2", rs2_data, (rs2_addr == 0) ? 32'd0 :
                  (wb_valid && !dbg_hold && wb_rd == rs2_addr) ? wb_data : model[rs2_addr]);
            step();
        end
        wb_valid = 1'b0; dbg_hold = 1'b0;
        step();

        force dut.commit_cnt = 32'hFFFFFFFF;
        #1 release dut.commit_cnt;
        cnt = 32'hFFFFFFFF;
        write(4'd4, 32'h44444444);
        check("cnt_wrap", commit_cnt, 32'd0);

        wb_valid = 1'b1; wb_rd = 4'd6; wb_data = 32'h66666666;
        #2 rst = 1'b1;
        model_reset();
        #1 check("rst_mid_x4", dbg_regs[4*32 +: 32], 32'd0);
        check("rst_mid_ready", {31'b0, wb_ready}, 32'd0);
        step();
        rst = 1'b0; wb_valid = 1'b0;
        rs1_addr = 4'd6;
        #1 check("rst_abort_x6", rs1_data, 32'd0);
        check("rst_abort_cnt", commit_cnt, 32'd0);
        step();
        check("no_valid_after_rst", {31'b0, dbg_valid}, 32'd0);
        check("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
